// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// dmem_access_unit : RV32I load/store sequencer for a word-wide data_memory
// Revision 1.0
// ============================================================================
module dmem_access_unit #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] data_addr,
  output logic [31:0] w_data_mem,
  output logic        r_en_mem,
  output logic        w_en_mem,
  input  logic [31:0] r_data_mem
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [32:0] c_dmem_limit = 33'(DMEM_BYTES);

  state_t      r_state, w_state_nxt;
  logic        r_we, w_we_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic [1:0]  r_addr_lo, w_addr_lo_nxt;
  logic [15:0] r_wdata_lo, w_wdata_lo_nxt;
  logic        w_err_nxt;
  logic [31:0] w_rdata_nxt, w_daddr_nxt, w_wdata_nxt;
  logic        w_misalign, w_bad_funct3, w_out_of_range, w_req_err;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // data_memory only writes whole words, so sub-word stores splice into the word just read
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (f3 == 3'b000) begin
      case (a)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (a[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  always_comb begin
    w_misalign     = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    w_bad_funct3   = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    w_out_of_range = ({1'b0, req_addr} + 33'd3) >= c_dmem_limit;
    w_req_err      = w_misalign || w_bad_funct3 || w_out_of_range;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_we_nxt       = r_we;
    w_funct3_nxt   = r_funct3;
    w_addr_lo_nxt  = r_addr_lo;
    w_wdata_lo_nxt = r_wdata_lo;
    w_err_nxt      = 1'b0;
    w_rdata_nxt    = 32'd0;
    w_daddr_nxt    = data_addr;
    w_wdata_nxt    = w_data_mem;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_we_nxt       = req_we;
          w_funct3_nxt   = req_funct3;
          w_addr_lo_nxt  = req_addr[1:0];
          w_wdata_lo_nxt = req_wdata[15:0];
          if (w_req_err) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
          end else begin
            w_daddr_nxt = {req_addr[31:2], 2'b00};
            if (!req_we || req_funct3[1:0] != 2'b10) begin
              w_state_nxt = S_READ;
            end else begin
              w_state_nxt = S_WRITE;
              w_wdata_nxt = req_wdata;
            end
          end
        end
      end
      S_READ:    w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (!r_we) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = load_extract(r_funct3, r_addr_lo, r_data_mem);
        end else begin
          w_state_nxt = S_WRITE;
          w_wdata_nxt = store_merge(r_funct3, r_addr_lo, r_data_mem, r_wdata_lo);
        end
      end
      S_WRITE:   w_state_nxt = S_RESP;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_wdata_lo <= 16'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      data_addr  <= 32'd0;
      w_data_mem <= 32'd0;
      r_en_mem   <= 1'b0;
      w_en_mem   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_we       <= w_we_nxt;
      r_funct3   <= w_funct3_nxt;
      r_addr_lo  <= w_addr_lo_nxt;
      r_wdata_lo <= w_wdata_lo_nxt;
      req_ready  <= (w_state_nxt == S_IDLE);
      resp_valid <= (w_state_nxt == S_RESP);
      resp_err   <= w_err_nxt;
      resp_rdata <= w_rdata_nxt;
      data_addr  <= w_daddr_nxt;
      w_data_mem <= w_wdata_nxt;
      r_en_mem   <= (w_state_nxt == S_READ);
      w_en_mem   <= (w_state_nxt == S_WRITE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_dmem_access_unit : directed + random bench with a byte-level memory model
// Revision 1.0
// ============================================================================
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, data_addr, w_data_mem, r_data_mem;
  logic        r_en_mem, w_en_mem;

  int total = 0;
  int bad   = 0;

  logic [7:0] dm   [0:1023];
  logic [7:0] refm [0:1023];

  always #5 clk = ~clk;

  dmem_access_unit #(.DMEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .data_addr(data_addr), .w_data_mem(w_data_mem),
    .r_en_mem(r_en_mem), .w_en_mem(w_en_mem), .r_data_mem(r_data_mem)
  );

  // data_memory stand-in: registered read, whole-word write
  always @(posedge clk) begin
    r_data_mem <= r_en_mem ? {dm[{data_addr[9:2], 2'd3}], dm[{data_addr[9:2], 2'd2}],
                              dm[{data_addr[9:2], 2'd1}], dm[{data_addr[9:2], 2'd0}]} : 32'd0;
    if (w_en_mem) begin
      dm[{data_addr[9:2], 2'd0}] <= w_data_mem[7:0];
      dm[{data_addr[9:2], 2'd1}] <= w_data_mem[15:8];
      dm[{data_addr[9:2], 2'd2}] <= w_data_mem[23:16];
      dm[{data_addr[9:2], 2'd3}] <= w_data_mem[31:24];
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    if (addr % access_size(f3) != 0) return 1'b1;
    return (longint'(addr) + 3 >= 1024);
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {refm[a + 3], refm[a + 2], refm[a + 1], refm[a]};
  endfunction

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold,
                       output logic [31:0] got, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd, exp_wword, aligned;
    int          size, exp_lat, exp_nr, exp_nw, lat, nr, nw, ov, a;
    exp_err   = ref_err(we, f3, addr);
    size      = access_size(f3);
    aligned   = {addr[31:2], 2'b00};
    a         = int'(addr[9:0]);
    exp_rd    = 32'd0;
    exp_wword = 32'd0;
    if (!exp_err && !we) begin
      case (f3)
        3'd0: exp_rd = 32'($signed(refm[a]));
        3'd4: exp_rd = 32'(refm[a]);
        3'd1: exp_rd = 32'($signed({refm[a + 1], refm[a]}));
        3'd5: exp_rd = 32'({refm[a + 1], refm[a]});
        default: exp_rd = ref_word(a);
      endcase
    end
    if (!exp_err && we) begin
      for (int i = 0; i < size; i++) refm[a + i] = wdata[8*i +: 8];
      exp_wword = ref_word(int'(aligned[9:0]));
    end
    exp_lat = exp_err ? 1 : (!we ? 3 : (size == 4 ? 2 : 4));
    exp_nr  = (exp_err || (we && size == 4)) ? 0 : 1;
    exp_nw  = (!exp_err && we) ? 1 : 0;

    check("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid  = hold;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = -1; nr = 0; nw = 0; ov = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (r_en_mem && w_en_mem) ov++;
      if (r_en_mem) begin
        nr++;
        check("read_addr", data_addr, aligned);
      end
      if (w_en_mem) begin
        nw++;
        check("write_addr", data_addr, aligned);
        check("write_word", w_data_mem, exp_wword);
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("read_count", 32'(nr), 32'(exp_nr));
    check("write_count", 32'(nw), 32'(exp_nw));
    check("en_overlap", 32'(ov), 32'd0);
    got     = resp_rdata;
    got_err = resp_err;
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  task automatic rand_op(input bit hold);
    logic        we, e;
    logic [2:0]  f3;
    logic [31:0] addr, g;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
    else if (we)                   f3 = 3'($urandom_range(0, 2));
    else begin
      f3 = 3'($urandom_range(0, 4));
      if (f3 == 3'd3) f3 = 3'd5;
    end
    if ($urandom_range(0, 15) == 0) addr = $urandom;
    else addr = 32'($urandom_range(0, 1023));
    do_op(we, f3, addr, $urandom, hold, g, e);
  endtask

  initial begin
    logic [31:0] got, saved;
    logic        err;
    int          seen;

    for (int i = 0; i < 1024; i++) begin
      dm[i]   = 8'($urandom);
      refm[i] = dm[i];
    end
    dm[16] = 8'h83; dm[17] = 8'h82; dm[18] = 8'h81; dm[19] = 8'h80;
    for (int i = 16; i < 20; i++) refm[i] = dm[i];

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_r_en", 32'(r_en_mem), 32'd0);
    check("rst_w_en", 32'(w_en_mem), 32'd0);
    check("rst_data_addr", data_addr, 32'd0);
    check("rst_w_data", w_data_mem, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b0, 3'b000, 32'h11, 32'd0, 1'b0, got, err); check("lb_11", got, 32'hFFFFFF82);
    do_op(1'b0, 3'b100, 32'h13, 32'd0, 1'b0, got, err); check("lbu_13", got, 32'h00000080);
    do_op(1'b0, 3'b001, 32'h12, 32'd0, 1'b0, got, err); check("lh_12", got, 32'hFFFF8081);
    do_op(1'b0, 3'b101, 32'h12, 32'd0, 1'b0, got, err); check("lhu_12", got, 32'h00008081);
    do_op(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, got, err); check("lw_10", got, 32'h80818283);

    do_op(1'b1, 3'b000, 32'h12, 32'h1234565A, 1'b0, got, err);
    do_op(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, got, err); check("lw_after_sb", got, 32'h805A8283);

    do_op(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b0, got, err);
    do_op(1'b1, 3'b001, 32'h22, 32'h0000CAFE, 1'b0, got, err);
    do_op(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, got, err); check("lw_after_sh", got, 32'hCAFEBEEF);

    do_op(1'b0, 3'b010, 32'h11, 32'd0, 1'b0, got, err); check("err_lw_11", 32'(err), 32'd1);
    do_op(1'b0, 3'b001, 32'h13, 32'd0, 1'b0, got, err); check("err_lh_13", 32'(err), 32'd1);
    do_op(1'b0, 3'b011, 32'h10, 32'd0, 1'b0, got, err); check("err_f3_011", 32'(err), 32'd1);
    do_op(1'b0, 3'b010, 32'h3FE, 32'd0, 1'b0, got, err); check("err_lw_3fe", 32'(err), 32'd1);
    do_op(1'b1, 3'b010, 32'h3FC, 32'h01020304, 1'b0, got, err); check("ok_sw_3fc", 32'(err), 32'd0);

    // reset lands during CAPTURE of a byte store: nothing may reach memory
    saved = ref_word(32'h30);
    check("abort_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'hA5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_read_phase", 32'(r_en_mem), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", 32'(req_ready), 32'd1);
    check("abort_no_write", 32'(w_en_mem), 32'd0);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || w_en_mem) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    do_op(1'b0, 3'b010, 32'h30, 32'd0, 1'b0, got, err); check("abort_mem_kept", got, saved);

    for (int k = 0; k < 40; k++) rand_op(1'b1);
    req_valid = 1'b0;
    for (int k = 0; k < 60; k++) rand_op(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
